// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// Word <-> half-word address mapping lives here too.
package mem_stage_sram_ctrl_pkg;

   localparam int DEF_WORD_LEN      = 32;
   localparam int DEF_ADDRESS_LEN   = 32;
   localparam int DEF_SRAM_ADDR_LEN = 18;
   localparam int DEF_SRAM_DATA_LEN = 16;
   localparam int DEF_SRAM_WAIT     = 5;
   localparam int DEF_BASE_ADDR     = 1024;
   localparam int CNT_LEN           = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Word index inside SRAM; byte offset bits and high bits are dropped.
   function automatic logic [DEF_SRAM_ADDR_LEN-2:0] word_idx(
      input logic [DEF_ADDRESS_LEN-1:0] addr,
      input logic [DEF_ADDRESS_LEN-1:0] base
   );
      logic [DEF_ADDRESS_LEN-1:0] off;
      off = addr - base;
      return off[DEF_SRAM_ADDR_LEN:2];
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Cycle counter pacing each SRAM half-access.
// Wraps to zero after flagging the last cycle.
module sram_wait_counter
   import mem_stage_sram_ctrl_pkg::*;
#(
   parameter int WAIT = DEF_SRAM_WAIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   logic [CNT_LEN-1:0] count;

   assign last = (count == CNT_LEN'(WAIT - 1));

   // Count busy cycles, restarting at every half-access boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= last ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit load/store as two 16-bit async SRAM accesses.
// Freezes the pipeline until the access reaches DONE.
module mem_stage_sram_ctrl
   import mem_stage_sram_ctrl_pkg::*;
#(
   parameter int WORD_LEN      = DEF_WORD_LEN,
   parameter int ADDRESS_LEN   = DEF_ADDRESS_LEN,
   parameter int SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
   parameter int SRAM_DATA_LEN = DEF_SRAM_DATA_LEN,
   parameter int SRAM_WAIT     = DEF_SRAM_WAIT,
   parameter int BASE_ADDR     = DEF_BASE_ADDR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     MEM_R_EN,
   input  logic                     MEM_W_EN,
   input  logic [ADDRESS_LEN-1:0]   ALU_Res,
   input  logic [WORD_LEN-1:0]      Val_Rm,
   output logic [WORD_LEN-1:0]      memory_out,
   output logic                     freeze,
   output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
   output logic                     SRAM_WE_N,
   output logic [SRAM_DATA_LEN-1:0] SRAM_DQ_OUT,
   output logic                     SRAM_DQ_OE,
   input  logic [SRAM_DATA_LEN-1:0] SRAM_DQ_IN
);

   state_t state, next_state;
   logic [SRAM_ADDR_LEN-2:0] idx_q;
   logic [WORD_LEN-1:0]      data_q;
   logic busy, last, req;

   assign req  = MEM_R_EN | MEM_W_EN;
   assign busy = (state == RD_LO) || (state == RD_HI) ||
                 (state == WR_LO) || (state == WR_HI);

   sram_wait_counter #(.WAIT(SRAM_WAIT)) u_wait (
      .clk  (clk),
      .rst  (rst),
      .clr  (!busy),
      .en   (busy),
      .last (last)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Sequence the two halves; reads win over simultaneous writes.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (MEM_R_EN)      next_state = RD_LO;
                  else if (MEM_W_EN) next_state = WR_LO;
         RD_LO:   if (last) next_state = RD_HI;
         RD_HI:   if (last) next_state = DONE;
         WR_LO:   if (last) next_state = WR_HI;
         WR_HI:   if (last) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture address and store data when an access is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q  <= '0;
         data_q <= '0;
      end else if (state == IDLE && req) begin
         idx_q  <= word_idx(ALU_Res, ADDRESS_LEN'(BASE_ADDR));
         data_q <= Val_Rm;
      end
   end

   // Assemble the loaded word on the last cycle of each read half.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         memory_out <= '0;
      else if (state == RD_LO && last)
         memory_out[SRAM_DATA_LEN-1:0] <= SRAM_DQ_IN;
      else if (state == RD_HI && last)
         memory_out[WORD_LEN-1:SRAM_DATA_LEN] <= SRAM_DQ_IN;
   end

   // Bus drive and stall; WE_N rises on the last cycle to hold data.
   always_comb begin
      SRAM_ADDR   = '0;
      SRAM_WE_N   = 1'b1;
      SRAM_DQ_OE  = 1'b0;
      SRAM_DQ_OUT = '0;
      freeze      = 1'b0;
      unique case (state)
         IDLE: freeze = rst & req;
         RD_LO: begin
            SRAM_ADDR = {idx_q, 1'b0};
            freeze    = 1'b1;
         end
         RD_HI: begin
            SRAM_ADDR = {idx_q, 1'b1};
            freeze    = 1'b1;
         end
         WR_LO: begin
            SRAM_ADDR   = {idx_q, 1'b0};
            SRAM_DQ_OE  = 1'b1;
            SRAM_DQ_OUT = data_q[SRAM_DATA_LEN-1:0];
            SRAM_WE_N   = last;
            freeze      = 1'b1;
         end
         WR_HI: begin
            SRAM_ADDR   = {idx_q, 1'b1};
            SRAM_DQ_OE  = 1'b1;
            SRAM_DQ_OUT = data_q[WORD_LEN-1:SRAM_DATA_LEN];
            SRAM_WE_N   = last;
            freeze      = 1'b1;
         end
         DONE: freeze = 1'b0;
         default: freeze = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with SRAM_WAIT=2.
// A behavioural SRAM hangs off the bus.
module tb_mem_stage_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [31:0] alu_res = '0;
   logic [31:0] val_rm = '0;
   logic [31:0] memory_out;
   logic        freeze;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;

   logic [15:0] sram [0:63];

   int checks = 0;
   int errors = 0;

   int          rec_frz, rec_wel, rec_oe;
   logic [17:0] rec_adr [8];
   logic        rec_we [8];
   logic [31:0] rec_mout;
   logic        rec_tmo;

   always #5 clk = ~clk;

   mem_stage_sram_ctrl #(.SRAM_WAIT(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .MEM_R_EN    (mem_r_en),
      .MEM_W_EN    (mem_w_en),
      .ALU_Res     (alu_res),
      .Val_Rm      (val_rm),
      .memory_out  (memory_out),
      .freeze      (freeze),
      .SRAM_ADDR   (sram_addr),
      .SRAM_WE_N   (sram_we_n),
      .SRAM_DQ_OUT (sram_dq_out),
      .SRAM_DQ_OE  (sram_dq_oe),
      .SRAM_DQ_IN  (sram_dq_in)
   );

   assign sram_dq_in = sram[sram_addr[5:0]];

   always @(posedge clk)
      if (!sram_we_n && sram_dq_oe)
         sram[sram_addr[5:0]] <= sram_dq_out;

   // Drive one request until freeze drops, logging bus activity.
   task automatic run_access(input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
      logic fin;
      for (int k = 0; k < 8; k++) begin
         rec_adr[k] = '1;
         rec_we[k]  = 1'b1;
      end
      rec_frz = 0; rec_wel = 0; rec_oe = 0;
      rec_mout = '0; rec_tmo = 1'b1; fin = 1'b0;
      mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
      for (int i = 0; i < 40 && !fin; i++) begin
         @(negedge clk);
         if (freeze) begin
            if (rec_frz < 8) begin
               rec_adr[rec_frz] = sram_addr;
               rec_we[rec_frz]  = sram_we_n;
            end
            rec_frz++;
            if (!sram_we_n) rec_wel++;
            if (sram_dq_oe) rec_oe++;
         end else begin
            rec_mout = memory_out;
            rec_tmo  = 1'b0;
            fin      = 1'b1;
         end
         @(posedge clk); #1;
      end
      mem_r_en = 1'b0; mem_w_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b1; alu_res = 32'd1028;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (freeze !== 1'b0) begin
         errors++; $display("FAIL reset_freeze: got %b want 0", freeze);
      end
      checks++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_bus: we_n=%b oe=%b want 1 0", sram_we_n, sram_dq_oe);
      end
      checks++;
      if (memory_out !== 32'h0 || sram_addr !== 18'h0) begin
         errors++;
         $display("FAIL reset_regs: mout=%h addr=%h want 0 0", memory_out, sram_addr);
      end
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
      checks++;
      if (rec_tmo !== 1'b0 || rec_frz != 5) begin
         errors++; $display("FAIL store_freeze: got %0d cycles tmo=%b want 5", rec_frz, rec_tmo);
      end
      checks++;
      if ({rec_we[1], rec_we[2], rec_we[3], rec_we[4]} !== 4'b0101 || rec_wel != 2) begin
         errors++;
         $display("FAIL store_we: pat=%b%b%b%b low=%0d want 0101 2",
                  rec_we[1], rec_we[2], rec_we[3], rec_we[4], rec_wel);
      end
      checks++;
      if (rec_oe != 4) begin
         errors++; $display("FAIL store_oe: got %0d want 4", rec_oe);
      end
      checks++;
      if (rec_adr[1] !== 18'd2 || rec_adr[2] !== 18'd2 ||
          rec_adr[3] !== 18'd3 || rec_adr[4] !== 18'd3) begin
         errors++;
         $display("FAIL store_addr: got %0d %0d %0d %0d want 2 2 3 3",
                  rec_adr[1], rec_adr[2], rec_adr[3], rec_adr[4]);
      end
      checks++;
      if (sram[2] !== 16'hBEEF || sram[3] !== 16'hDEAD) begin
         errors++; $display("FAIL store_data: got %h %h want beef dead", sram[2], sram[3]);
      end
      checks++;
      if (rec_mout !== 32'h0) begin
         errors++; $display("FAIL store_mout_hold: got %h want 0", rec_mout);
      end
   endtask

   task automatic test_load();
      run_access(1'b1, 1'b0, 32'd1028, 32'h0);
      checks++;
      if (rec_tmo !== 1'b0 || rec_frz != 5) begin
         errors++; $display("FAIL load_freeze: got %0d cycles tmo=%b want 5", rec_frz, rec_tmo);
      end
      checks++;
      if (rec_wel != 0 || rec_oe != 0) begin
         errors++; $display("FAIL load_bus: we_low=%0d oe=%0d want 0 0", rec_wel, rec_oe);
      end
      checks++;
      if (rec_adr[1] !== 18'd2 || rec_adr[2] !== 18'd2 ||
          rec_adr[3] !== 18'd3 || rec_adr[4] !== 18'd3) begin
         errors++;
         $display("FAIL load_addr: got %0d %0d %0d %0d want 2 2 3 3",
                  rec_adr[1], rec_adr[2], rec_adr[3], rec_adr[4]);
      end
      checks++;
      if (rec_mout !== 32'hDEADBEEF) begin
         errors++; $display("FAIL load_data: got %h want deadbeef", rec_mout);
      end
   endtask

   task automatic test_simultaneous();
      run_access(1'b0, 1'b1, 32'd1024, 32'h22221111);
      checks++;
      if (sram[0] !== 16'h1111 || sram[1] !== 16'h2222) begin
         errors++; $display("FAIL simul_setup: got %h %h want 1111 2222", sram[0], sram[1]);
      end
      run_access(1'b1, 1'b1, 32'd1024, 32'h99999999);
      checks++;
      if (rec_tmo !== 1'b0 || rec_frz != 5 || rec_wel != 0 || rec_oe != 0) begin
         errors++;
         $display("FAIL simul_read_only: frz=%0d we_low=%0d oe=%0d want 5 0 0",
                  rec_frz, rec_wel, rec_oe);
      end
      checks++;
      if (rec_adr[1] !== 18'd0 || rec_adr[3] !== 18'd1) begin
         errors++; $display("FAIL simul_addr: got %0d %0d want 0 1", rec_adr[1], rec_adr[3]);
      end
      checks++;
      if (rec_mout !== 32'h22221111) begin
         errors++; $display("FAIL simul_data: got %h want 22221111", rec_mout);
      end
      checks++;
      if (sram[0] !== 16'h1111 || sram[1] !== 16'h2222) begin
         errors++; $display("FAIL simul_sram: got %h %h want 1111 2222", sram[0], sram[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] fz;
      logic [31:0] mid_mout;
      logic [17:0] idle_adr;
      logic        idle_we;
      fz = '0; mid_mout = '0; idle_adr = '1; idle_we = 1'b0;
      mem_r_en = 1'b1; mem_w_en = 1'b0; alu_res = 32'd1028; val_rm = 32'h0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         fz[11-i] = freeze;
         if (i == 5) mid_mout = memory_out;
         if (i == 6) begin
            idle_adr = sram_addr;
            idle_we  = sram_we_n;
         end
         @(posedge clk); #1;
         if (i == 5) begin
            mem_r_en = 1'b0; mem_w_en = 1'b1;
            alu_res = 32'd1032; val_rm = 32'hCAFEF00D;
         end
         if (i == 11) mem_w_en = 1'b0;
      end
      checks++;
      if (fz !== 12'b111110111110) begin
         errors++; $display("FAIL b2b_freeze: got %b want 111110111110", fz);
      end
      checks++;
      if (mid_mout !== 32'hDEADBEEF) begin
         errors++; $display("FAIL b2b_load: got %h want deadbeef", mid_mout);
      end
      checks++;
      if (idle_adr !== 18'd0 || idle_we !== 1'b1) begin
         errors++; $display("FAIL b2b_idle: addr=%0d we_n=%b want 0 1", idle_adr, idle_we);
      end
      checks++;
      if (sram[4] !== 16'hF00D || sram[5] !== 16'hCAFE) begin
         errors++; $display("FAIL b2b_store: got %h %h want f00d cafe", sram[4], sram[5]);
      end
      checks++;
      if (memory_out !== 32'hDEADBEEF) begin
         errors++; $display("FAIL b2b_hold: got %h want deadbeef", memory_out);
      end
   endtask

   task automatic test_reset_mid();
      logic hi_we;
      hi_we = 1'b1;
      mem_r_en = 1'b0; mem_w_en = 1'b1; alu_res = 32'd1036; val_rm = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 3) hi_we = sram_we_n;
         if (i < 3) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (hi_we !== 1'b0 || sram_addr !== 18'd7) begin
         errors++; $display("FAIL mid_in_wr_hi: we_n=%b addr=%0d want 0 7", hi_we, sram_addr);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0) begin
         errors++;
         $display("FAIL mid_abort: we_n=%b oe=%b addr=%0d want 1 0 0",
                  sram_we_n, sram_dq_oe, sram_addr);
      end
      mem_w_en = 1'b0;
      #1;
      checks++;
      if (freeze !== 1'b0 || memory_out !== 32'h0) begin
         errors++; $display("FAIL mid_freeze: freeze=%b mout=%h want 0 0", freeze, memory_out);
      end
      checks++;
      if (sram[6] !== 16'h5678) begin
         errors++; $display("FAIL mid_partial: got %h want 5678", sram[6]);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_access(1'b1, 1'b0, 32'd1036, 32'h0);
      checks++;
      if (rec_tmo !== 1'b0 || rec_frz != 5 || rec_mout[15:0] !== 16'h5678) begin
         errors++;
         $display("FAIL mid_recover: frz=%0d lo=%h want 5 5678", rec_frz, rec_mout[15:0]);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
